// File: rtl/rr_mux_pkg.sv
// Shared constants and helpers for the rr_mux valid/ready arbitrating multiplexer.
package rr_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   function automatic int unsigned ch_w(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: fixed priority from index 0, or round robin starting at ptr.
module rr_arbiter
   import rr_mux_pkg::*;
#(
   parameter int unsigned N_CH = 4,
   localparam int unsigned CH_W = ch_w(N_CH)
) (
   input  logic [N_CH-1:0] req,
   input  logic [CH_W-1:0] ptr,
   input  logic            mode,
   output logic [N_CH-1:0] grant,
   output logic [CH_W-1:0] gidx,
   output logic            any_grant
);

   logic [2*N_CH-1:0] dbl;
   int unsigned       start;

   // Two copies of req side by side: bits below start are masked off, so the
   // first hit at or above start is the wrapped round-robin winner.
   always_comb begin
      dbl       = {req, req};
      start     = (mode == MODE_RR) ? 32'(ptr) : 32'd0;
      gidx      = '0;
      any_grant = 1'b0;
      for (int unsigned k = 0; k < 2 * N_CH; k++) begin
         if (!any_grant && k >= start && dbl[k]) begin
            any_grant = 1'b1;
            gidx      = CH_W'(k % N_CH);
         end
      end
   end

   always_comb begin
      grant = '0;
      if (any_grant)
         grant[gidx] = 1'b1;
   end

endmodule

// File: rtl/rr_mux.sv
// N-channel registered multiplexer with valid/ready on every port and fixed or round-robin arbitration.
module rr_mux
   import rr_mux_pkg::*;
#(
   parameter int unsigned N_CH  = 4,
   parameter int unsigned WIDTH = 8,
   localparam int unsigned CH_W = ch_w(N_CH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  mode,
   input  logic [N_CH*WIDTH-1:0] in_data,
   input  logic [N_CH-1:0]       in_valid,
   output logic [N_CH-1:0]       in_ready,
   output logic [WIDTH-1:0]      out_data,
   output logic [CH_W-1:0]       out_ch,
   output logic                  out_valid,
   input  logic                  out_ready
);

   logic [CH_W-1:0]  ptr;
   logic [N_CH-1:0]  grant;
   logic [CH_W-1:0]  gidx;
   logic             any_grant;
   logic             load_en;
   logic [WIDTH-1:0] sel_data;
   logic [CH_W-1:0]  ptr_next;

   rr_arbiter #(.N_CH(N_CH)) u_arb (
      .req       (in_valid),
      .ptr       (ptr),
      .mode      (mode),
      .grant     (grant),
      .gidx      (gidx),
      .any_grant (any_grant)
   );

   always_comb begin
      load_en  = !out_valid || out_ready;
      // rst_n gate keeps every in_ready low while reset is held.
      in_ready = (load_en && rst_n) ? grant : '0;
      sel_data = in_data[32'(gidx)*WIDTH +: WIDTH];
      ptr_next = (gidx == CH_W'(N_CH - 1)) ? '0 : gidx + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_data  <= '0;
         out_ch    <= '0;
         ptr       <= '0;
      end else if (load_en) begin
         if (any_grant) begin
            out_data  <= sel_data;
            out_ch    <= gidx;
            out_valid <= 1'b1;
            if (mode == MODE_RR)
               ptr <= ptr_next;
         end else begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_rr_mux.sv
// Directed self-checking bench for rr_mux with N_CH=4, WIDTH=8 and hand-computed expectations.
module tb_rr_mux;

   logic        clk;
   logic        rst_n;
   logic        mode;
   logic [31:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [7:0]  out_data;
   logic [1:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   rr_mux #(.N_CH(4), .WIDTH(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_out(input string tag, input logic v, input logic [1:0] ch, input logic [7:0] d);
      check({tag, "_valid"}, 32'(out_valid), 32'(v));
      check({tag, "_ch"},    32'(out_ch),    32'(ch));
      check({tag, "_data"},  32'(out_data),  32'(d));
   endtask

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b1;
      in_data   = 32'h13121110;
      in_valid  = 4'b1111;
      out_ready = 1'b1;

      // reset state with every channel requesting
      #12;
      check_out("reset", 1'b0, 2'd0, 8'h00);
      check("reset_in_ready", 32'(in_ready), 32'h0);

      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'b0001);

      // round robin, all valid, no bubbles
      for (int k = 0; k < 6; k++) begin
         step();
         check_out("rr", 1'b1, 2'(k % 4), 8'(8'h10 + k % 4));
      end
      // ptr is now 2

      // fixed priority: ch1 always beats ch3, ptr untouched
      mode     = 1'b0;
      in_valid = 4'b1010;
      #1;
      check("fp_in_ready", 32'(in_ready), 32'b0010);
      for (int k = 0; k < 3; k++) begin
         step();
         check_out("fp", 1'b1, 2'd1, 8'h11);
      end

      // back to round robin: ptr kept at 2 -> ch2
      mode     = 1'b1;
      in_valid = 4'b1111;
      #1;
      check("rr_resume_in_ready", 32'(in_ready), 32'b0100);
      step();
      check_out("rr_resume", 1'b1, 2'd2, 8'h12);

      // backpressure: hold ch2 word for 3 cycles
      out_ready = 1'b0;
      #1;
      check("stall_in_ready", 32'(in_ready), 32'h0);
      for (int k = 0; k < 3; k++) begin
         step();
         check_out("stall", 1'b1, 2'd2, 8'h12);
         check("stall_in_ready_hold", 32'(in_ready), 32'h0);
      end

      // ptr=3, only ch0 requests: wrap scan, same-cycle consume+reload
      in_valid  = 4'b0001;
      out_ready = 1'b1;
      #1;
      check("wrap_in_ready", 32'(in_ready), 32'b0001);
      step();
      check_out("wrap", 1'b1, 2'd0, 8'h10);

      in_valid = 4'b1111;
      #1;
      check("ptr_after_wrap", 32'(in_ready), 32'b0010);

      // no requests: one consume then out_valid drops, data/ch held
      in_valid = 4'b0000;
      #1;
      check("idle_in_ready", 32'(in_ready), 32'h0);
      step();
      check_out("drain", 1'b0, 2'd0, 8'h10);

      // reset during a stall
      in_valid = 4'b1111;
      step();
      check_out("pre_rst", 1'b1, 2'd1, 8'h11);
      out_ready = 1'b0;
      step();
      check_out("pre_rst_stall", 1'b1, 2'd1, 8'h11);
      #2;
      rst_n = 1'b0;
      #1;
      check_out("async_rst", 1'b0, 2'd0, 8'h00);
      check("async_rst_in_ready", 32'(in_ready), 32'h0);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      #1;
      check("post_rst_in_ready", 32'(in_ready), 32'b0001);
      step();
      check_out("post_rst", 1'b1, 2'd0, 8'h10);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/rr_mux.md
# rr_mux

Parametrised N-channel, W-bit multiplexer with valid/ready handshakes on every input and on the output. It is the registered successor of the 2:1 NOR-gate mux. Each cycle it selects one requesting channel, by fixed priority or round robin, and lands the data in an output register. It sits between several producer streams and a single consumer wherever one shared datapath must be time-shared fairly.

## Interface
Parameters:
- N_CH, 4, number of input channels (2..16)
- WIDTH, 8, data width per channel (≥1)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- mode  in  1  0 = fixed priority (lowest index wins), 1 = round robin
- in_data  in  N_CH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH]
- in_valid  in  N_CH  per-channel request
- in_ready  out  N_CH  per-channel accept, one-hot or zero
- out_data  out  WIDTH  registered selected data
- out_ch  out  CH_W  index of the channel that supplied out_data; CH_W = max(1, $clog2(N_CH))
- out_valid  out  1  output register holds a word
- out_ready  in  1  consumer accept

## Operation
- Transfer on any port occurs when valid && ready are both high at a rising edge.
- load_en = !out_valid || out_ready. The output register accepts a new word only when load_en is high.
- Grant selection (combinational, from in_valid, mode, ptr):
  - mode 0: lowest-index i with in_valid[i].
  - mode 1: first i with in_valid[i], scanning ptr, ptr+1, … N_CH-1, 0, … ptr-1 (wraps).
  - No valid input: no grant.
- in_ready[i] = load_en && grant[i]. At most one bit is high. in_ready is zero when nothing is valid.
- On a transfer from channel g:
  - out_data ← in_data[g]
  - out_ch ← g
  - out_valid ← 1
  - mode 1 only: ptr ← (g+1) mod N_CH, so g = N_CH-1 wraps to 0.
- Output consumed (out_valid && out_ready) with no new grant: out_valid ← 0. out_data and out_ch hold their last value.
- Consume and new grant in the same cycle: the register reloads, out_valid stays 1, and there is no bubble.
- Stall (out_valid && !out_ready): out_data, out_ch and out_valid are held stable and all in_ready are 0.
- Mode 0 never updates ptr. A mode change takes effect on the next grant evaluation, and ptr keeps its value across the change.
- A channel dropping in_valid without a transfer is legal. Arbitration re-evaluates every cycle and there is no lock.

## Timing
- Latency: input transfer at edge k makes out_valid high after edge k. The word is visible in cycle k+1.
- Throughput: one word per cycle while out_ready is held high.
- in_ready depends combinationally on in_valid, mode and out_ready. There is no path from in_data to any ready.
- Reset (asynchronous assert, synchronous-safe release):
  - out_valid = 0
  - out_data = 0
  - out_ch = 0
  - ptr = 0
  - in_ready = 0 while rst_n is low
- Reset asserted mid-operation: any held word is dropped without a transfer. The first grant after release starts at ptr 0.

## Structure
- Package rr_mux_pkg holds the ch_w(n) function (max(1, $clog2(n))) and mode constants MODE_FIXED = 1'b0 and MODE_RR = 1'b1.
- Sub-module rr_arbiter (params N_CH) is purely combinational: inputs req[N_CH], ptr, mode; outputs one-hot grant[N_CH], grant index gidx, any_grant. It is implemented as a double-width masked priority scan.
- rr_mux contains the ptr register, the output register, the load_en logic and the data select. The data select is an indexed part-select on gidx.

## Test plan
- Reset: rst_n=0 with in_valid=4'b1111 → out_valid=0, out_data=0, out_ch=0, in_ready=0. Release with out_ready=1 → first word from channel 0.
- Round robin fairness: mode=1, N_CH=4, all channels always valid with data = 8'h10+i, out_ready=1 → out_ch sequence 0,1,2,3,0,1 and out_data 10,11,12,13,10,11 with no bubbles.
- Fixed priority: mode=0, in_valid=4'b1010 held → every grant goes to ch1 (out_data 11). ch3 starves and ptr is unchanged.
- Backpressure: a word from ch2 is registered, then out_ready=0 for 3 cycles → out_data and out_ch are stable and in_ready=0. out_ready=1 → one consume plus a same-cycle reload from the next requester, with out_valid staying high.
- Wrap and sparse requests: mode=1, ptr=3 after a ch2 grant, in_valid=4'b0001 → ch0 granted and ptr becomes 1. With in_valid=0 → out_valid drops after one consume.
- Reset mid-stall: out_valid=1 with out_ready=0, then rst_n pulsed → out_valid=0 immediately (asynchronous) and the next grant scans from ch0.
